// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Purpose  : Shared constants, state type and address struct for matrix_loader
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

   localparam int MAX_ELEMENT_SIZE = 8;
   localparam int MAX_ROW_SIZE_A   = 32;
   localparam int MAX_COL_SIZE_A   = 32;
   localparam int MAX_ROW_SIZE_B   = 32;
   localparam int MAX_COL_SIZE_B   = 32;
   localparam int ADDR_W           = 10;
   localparam int DIM_W            = 6;
   localparam int CK_TIMEOUT       = 64;

   typedef enum logic [2:0] {
      ST_HDR     = 3'd0,
      ST_LOAD_A  = 3'd1,
      ST_LOAD_B  = 3'd2,
      ST_WAIT_CK = 3'd3,
      ST_DRAIN   = 3'd4
   } loader_state_t;

   typedef struct packed {
      logic [4:0] row;
      logic [4:0] col;
   } mat_addr_t;

   // A header dimension is legal when it lies in 1..max_v
   function automatic logic dim_in_range(input logic [MAX_ELEMENT_SIZE-1:0] v,
                                         input int max_v);
      return (v != '0) && (int'(v) <= max_v);
   endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_loader_if
// Purpose  : Element stream, checksum verdict and memory-write bundle
// Revision : 1.0 - initial release
// ============================================================================
interface matrix_loader_if;
   import matrix_pkg::*;

   logic                        axiiv;
   logic [MAX_ELEMENT_SIZE-1:0] axiid;
   logic                        frame_end;
   logic                        ck_done;
   logic                        ck_kill;
   logic                        a_we;
   logic                        b_we;
   logic [ADDR_W-1:0]           a_addr;
   logic [ADDR_W-1:0]           b_addr;
   logic [MAX_ELEMENT_SIZE-1:0] a_data;
   logic [MAX_ELEMENT_SIZE-1:0] b_data;
   logic [DIM_W-1:0]            rows_a;
   logic [DIM_W-1:0]            cols_a;
   logic [DIM_W-1:0]            cols_b;
   logic                        load_done;
   logic                        load_err;
   logic                        busy;

   // Upstream side: produces the stream and verdict, observes the loader
   modport master (
      output axiiv, axiid, frame_end, ck_done, ck_kill,
      input  a_we, b_we, a_addr, b_addr, a_data, b_data,
      input  rows_a, cols_a, cols_b, load_done, load_err, busy
   );

   // Loader side
   modport slave (
      input  axiiv, axiid, frame_end, ck_done, ck_kill,
      output a_we, b_we, a_addr, b_addr, a_data, b_data,
      output rows_a, cols_a, cols_b, load_done, load_err, busy
   );

endinterface
`default_nettype wire

// File: rtl/matrix_loader_rc_counter.sv
`default_nettype none
// ============================================================================
// Module   : rc_counter
// Purpose  : Row-major {row, col} address generator with last-element flag
// Revision : 1.0 - initial release
// ============================================================================
module rc_counter
   import matrix_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_step,
   input  logic [DIM_W-1:0] i_rows,
   input  logic [DIM_W-1:0] i_cols,
   output mat_addr_t        o_addr,
   output logic             o_last
);

   mat_addr_t r_pos;
   logic      w_col_end;
   logic      w_row_end;

   assign w_col_end = ({1'b0, r_pos.col} == (i_cols - DIM_W'(1)));
   assign w_row_end = ({1'b0, r_pos.row} == (i_rows - DIM_W'(1)));
   assign o_addr    = r_pos;
   assign o_last    = w_col_end && w_row_end;

   // Advance column, wrapping into the next row at the column bound
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_pos <= '0;
      end else if (i_step) begin
         if (w_col_end) begin
            r_pos.col <= '0;
            r_pos.row <= r_pos.row + 5'd1;
         end else begin
            r_pos.col <= r_pos.col + 5'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/matrix_loader.sv
`default_nettype none
// ============================================================================
// Module   : matrix_loader
// Purpose  : Parses a dimension header, writes matrices A and B to memory and
//            commits the dimensions once the frame checksum is reported good
// Revision : 1.0 - initial release
// ============================================================================
module matrix_loader
   import matrix_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   matrix_loader_if.slave     bus
);

   localparam int TO_W = $clog2(CK_TIMEOUT);

   loader_state_t               r_state;
   loader_state_t               w_state_nxt;
   logic [1:0]                  r_hdr_cnt;
   logic [MAX_ELEMENT_SIZE-1:0] r_ra, r_ca, r_rb;
   logic [DIM_W-1:0]            r_cb;
   logic [TO_W-1:0]             r_to;
   mat_addr_t                   w_pos;
   logic                        w_last;
   logic [DIM_W-1:0]            w_rows, w_cols;
   logic                        w_hdr_fourth, w_hdr_ok, w_abort, w_verdict;
   logic                        w_to_exp, w_elem_last, w_step, w_clr;
   logic                        w_a_we, w_b_we, w_done, w_err;
   logic                        r_a_we, r_b_we, r_done, r_err;
   logic [ADDR_W-1:0]           r_wr_addr;
   logic [MAX_ELEMENT_SIZE-1:0] r_wr_data;
   logic [DIM_W-1:0]            r_rows_a, r_cols_a, r_cols_b;

   // The 4th header element is checked as it arrives, before it is stored
   assign w_hdr_fourth = bus.axiiv && (r_hdr_cnt == 2'd3);
   assign w_hdr_ok     = dim_in_range(r_ra, MAX_ROW_SIZE_A)
                      && dim_in_range(r_ca, MAX_COL_SIZE_A)
                      && dim_in_range(r_rb, MAX_ROW_SIZE_B)
                      && dim_in_range(bus.axiid, MAX_COL_SIZE_B)
                      && (r_ca == r_rb);
   assign w_abort      = bus.frame_end || bus.ck_done || bus.ck_kill;
   assign w_verdict    = bus.ck_done || bus.ck_kill;
   assign w_to_exp     = (r_to == TO_W'(CK_TIMEOUT - 1));
   assign w_elem_last  = bus.axiiv && w_last;

   // One address generator serves both matrices; bounds follow the state
   assign w_rows = (r_state == ST_LOAD_B) ? DIM_W'(r_rb) : DIM_W'(r_ra);
   assign w_cols = (r_state == ST_LOAD_B) ? r_cb          : DIM_W'(r_ca);
   assign w_step = bus.axiiv && ((r_state == ST_LOAD_A) || (r_state == ST_LOAD_B));
   assign w_clr  = (w_state_nxt != r_state);

   rc_counter u_rc (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_step (w_step),
      .i_rows (w_rows),
      .i_cols (w_cols),
      .o_addr (w_pos),
      .o_last (w_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_HDR;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_HDR:     if (w_hdr_fourth) w_state_nxt = w_hdr_ok ? ST_LOAD_A : ST_DRAIN;
         ST_LOAD_A:  if (w_abort) w_state_nxt = ST_HDR;
                     else if (w_elem_last) w_state_nxt = ST_LOAD_B;
         // A final element paired with a verdict means the verdict is not ours
         ST_LOAD_B:  if (w_elem_last) w_state_nxt = w_verdict ? ST_HDR : ST_WAIT_CK;
                     else if (w_abort) w_state_nxt = ST_HDR;
         ST_WAIT_CK: if (w_verdict || w_to_exp) w_state_nxt = ST_HDR;
         ST_DRAIN:   if (bus.frame_end) w_state_nxt = ST_HDR;
         default:    w_state_nxt = ST_HDR;
      endcase
   end

   // Output decode: write strobes and result pulses before registering
   always_comb begin
      w_a_we = 1'b0;
      w_b_we = 1'b0;
      w_done = 1'b0;
      w_err  = 1'b0;
      unique case (r_state)
         ST_HDR:     w_err = w_hdr_fourth && !w_hdr_ok;
         ST_LOAD_A:  begin
                        w_a_we = bus.axiiv;
                        w_err  = w_abort;
                     end
         ST_LOAD_B:  begin
                        w_b_we = bus.axiiv;
                        w_err  = w_elem_last ? w_verdict : w_abort;
                     end
         ST_WAIT_CK: begin
                        w_done = bus.ck_done && !bus.ck_kill;
                        w_err  = bus.ck_kill || (!bus.ck_done && w_to_exp);
                     end
         default:    ;
      endcase
   end

   // Header capture; a short header at frame_end wipes the partial capture
   always_ff @(posedge clk) begin
      if (rst || ((r_state == ST_HDR) && bus.frame_end && !w_hdr_fourth)) begin
         r_hdr_cnt <= '0;
         r_ra      <= '0;
         r_ca      <= '0;
         r_rb      <= '0;
         r_cb      <= '0;
      end else if ((r_state == ST_HDR) && bus.axiiv) begin
         case (r_hdr_cnt)
            2'd0:    r_ra <= bus.axiid;
            2'd1:    r_ca <= bus.axiid;
            2'd2:    r_rb <= bus.axiid;
            default: r_cb <= bus.axiid[DIM_W-1:0];
         endcase
         r_hdr_cnt <= r_hdr_cnt + 2'd1;
      end
   end

   // Verdict timeout counter, running only while waiting for the checksum
   always_ff @(posedge clk) begin
      if (rst || (r_state != ST_WAIT_CK)) r_to <= '0;
      else                                r_to <= r_to + TO_W'(1);
   end

   // Registered outputs and committed dimensions
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_we    <= 1'b0;
         r_b_we    <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_rows_a  <= '0;
         r_cols_a  <= '0;
         r_cols_b  <= '0;
      end else begin
         r_a_we    <= w_a_we;
         r_b_we    <= w_b_we;
         r_wr_addr <= w_pos;
         r_wr_data <= bus.axiid;
         r_done    <= w_done;
         r_err     <= w_err;
         if (w_done) begin
            r_rows_a <= DIM_W'(r_ra);
            r_cols_a <= DIM_W'(r_ca);
            r_cols_b <= r_cb;
         end
      end
   end

   assign bus.a_we      = r_a_we;
   assign bus.b_we      = r_b_we;
   assign bus.a_addr    = r_wr_addr;
   assign bus.b_addr    = r_wr_addr;
   assign bus.a_data    = r_wr_data;
   assign bus.b_data    = r_wr_data;
   assign bus.rows_a    = r_rows_a;
   assign bus.cols_a    = r_cols_a;
   assign bus.cols_b    = r_cols_b;
   assign bus.load_done = r_done;
   assign bus.load_err  = r_err;
   assign bus.busy      = (r_state != ST_HDR);

endmodule
`default_nettype wire
